// File: rtl/mem_line_responder.sv
// Line-burst memory responder: services cache line fills and writebacks as
// BLOCKSIZE-word bursts after a fixed access latency.
module mem_line_responder #(
    parameter int AWIDTH    = 9,
    parameter int DWIDTH    = 32,
    parameter int BLOCKSIZE = 4,
    parameter int LATENCY   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_mem,
    input  logic              wr_mem,
    input  logic [AWIDTH-1:0] addr_mem,
    input  logic [DWIDTH-1:0] data_in,
    output logic [DWIDTH-1:0] data_out,
    output logic              ready_mem,
    output logic              last_mem,
    output logic              busy
);

    localparam int OFFW  = $clog2(BLOCKSIZE);
    localparam int CNTW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DEPTH = 1 << AWIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNTW-1:0]   lat_cnt;
    logic [OFFW-1:0]   beat;
    logic [OFFW-1:0]   beat_nxt;
    logic [AWIDTH-1:0] base;
    logic [AWIDTH-1:0] rd_addr;
    logic [AWIDTH-1:0] wr_addr;
    logic              dir_wr;
    logic              req;
    logic              wait_done;
    logic              last_beat;

    logic [DWIDTH-1:0] mem [DEPTH];

    assign req       = rd_mem | wr_mem;
    assign wait_done = (lat_cnt == '0);
    assign last_beat = (beat == OFFW'(BLOCKSIZE - 1));

    // Prefetch address for the beat about to start, so data_out is valid with ready_mem.
    assign beat_nxt = (state == XFER) ? beat + OFFW'(1) : '0;
    assign rd_addr  = base + AWIDTH'(beat_nxt);
    assign wr_addr  = base + AWIDTH'(beat);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req)       state_nxt = WAIT;
            WAIT:    if (wait_done) state_nxt = XFER;
            XFER:    if (last_beat) state_nxt = DONE;
            DONE:    if (!req)      state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt   <= '0;
            beat      <= '0;
            base      <= '0;
            dir_wr    <= 1'b0;
            busy      <= 1'b0;
            ready_mem <= 1'b0;
            last_mem  <= 1'b0;
            data_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        base    <= addr_mem & ~AWIDTH'(BLOCKSIZE - 1);
                        dir_wr  <= wr_mem;
                        lat_cnt <= CNTW'(LATENCY - 1);
                        busy    <= 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_done) begin
                        beat      <= '0;
                        ready_mem <= 1'b1;
                        last_mem  <= 1'b0;
                        if (!dir_wr) data_out <= mem[rd_addr];
                    end else begin
                        lat_cnt <= lat_cnt - CNTW'(1);
                    end
                end
                XFER: begin
                    if (last_beat) begin
                        ready_mem <= 1'b0;
                        last_mem  <= 1'b0;
                    end else begin
                        beat     <= beat_nxt;
                        last_mem <= (beat == OFFW'(BLOCKSIZE - 2));
                        if (!dir_wr) data_out <= mem[rd_addr];
                    end
                end
                DONE: begin
                    if (!req) busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Backing array is never reset; writeback beats land at the edge ending each beat.
    always_ff @(posedge clk) begin
        if (state == XFER && dir_wr) mem[wr_addr] <= data_in;
    end

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: table-driven bursts with a read-data scoreboard,
// plus hand-written reset-mid-write and top-of-array (LATENCY=1) sequences.
module tb_mem_line_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd = 1'b0, wr = 1'b0, sel = 1'b0;
    logic [8:0]  addr = '0;
    logic [31:0] din = '0;

    logic        rd_a, wr_a, rd_b, wr_b;
    logic [31:0] dout_a, dout_b, dout;
    logic        rdy_a, rdy_b, rdy, last_a, last_b, last, busy_a, busy_b, busy;

    assign rd_a = rd & ~sel;
    assign wr_a = wr & ~sel;
    assign rd_b = rd & sel;
    assign wr_b = wr & sel;
    assign dout = sel ? dout_b : dout_a;
    assign rdy  = sel ? rdy_b  : rdy_a;
    assign last = sel ? last_b : last_a;
    assign busy = sel ? busy_b : busy_a;

    always #5 clk = ~clk;

    mem_line_responder #(.AWIDTH(9), .DWIDTH(32), .BLOCKSIZE(4), .LATENCY(2)) dut_a (
        .clk(clk), .reset(reset), .rd_mem(rd_a), .wr_mem(wr_a), .addr_mem(addr),
        .data_in(din), .data_out(dout_a), .ready_mem(rdy_a), .last_mem(last_a), .busy(busy_a)
    );

    mem_line_responder #(.AWIDTH(9), .DWIDTH(32), .BLOCKSIZE(4), .LATENCY(1)) dut_b (
        .clk(clk), .reset(reset), .rd_mem(rd_b), .wr_mem(wr_b), .addr_mem(addr),
        .data_in(din), .data_out(dout_b), .ready_mem(rdy_b), .last_mem(last_b), .busy(busy_b)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd = '0;

    typedef struct {
        bit              r;
        bit              w;
        bit              drop_early;
        int              hold;
        logic [8:0]      a;
        logic [3:0][31:0] d;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transfer: request, latency, four beats, DONE hold, release.
    task automatic burst(input bit r, input bit w, input logic [8:0] a,
                         input logic [3:0][31:0] d, input int hold, input bit drop_early);
        int edges;
        int lat;
        logic [31:0] e;
        lat = sel ? 1 : 2;
        if (!w) for (int i = 0; i < 4; i++) exp_q.push_back(d[i]);
        rd = r; wr = w; addr = a; din = d[0];
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (drop_early && edges == 1) begin rd = 1'b0; wr = 1'b0; addr = ~a; end
        end while (!rdy && edges < 20);
        check("latency_edges", edges, lat + 1);
        for (int i = 0; i < 4; i++) begin
            din = d[i];
            check("ready_beat", {31'd0, rdy}, 32'd1);
            check("last_beat", {31'd0, last}, {31'd0, (i == 3)});
            check("busy_beat", {31'd0, busy}, 32'd1);
            if (!w) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check("rdata", dout, e);
                last_rd = e;
            end else begin
                check("dout_hold_wr", dout, last_rd);
            end
            @(posedge clk); #1;
        end
        check("ready_done", {31'd0, rdy}, 32'd0);
        check("last_done", {31'd0, last}, 32'd0);
        check("busy_done", {31'd0, busy}, 32'd1);
        check("dout_hold_done", dout, last_rd);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("ready_held", {31'd0, rdy}, 32'd0);
            check("busy_held", {31'd0, busy}, 32'd1);
        end
        rd = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        vecs[0] = '{r:0, w:1, drop_early:0, hold:0,  a:9'h013, d:{32'hA3, 32'hA2, 32'hA1, 32'hA0}};
        vecs[1] = '{r:1, w:0, drop_early:0, hold:0,  a:9'h010, d:{32'hA3, 32'hA2, 32'hA1, 32'hA0}};
        vecs[2] = '{r:1, w:1, drop_early:0, hold:0,  a:9'h020, d:{32'h55, 32'h55, 32'h55, 32'h55}};
        vecs[3] = '{r:1, w:0, drop_early:0, hold:0,  a:9'h020, d:{32'h55, 32'h55, 32'h55, 32'h55}};
        vecs[4] = '{r:0, w:1, drop_early:1, hold:0,  a:9'h044, d:{32'h4, 32'h3, 32'h2, 32'h1}};
        vecs[5] = '{r:1, w:0, drop_early:0, hold:20, a:9'h047, d:{32'h4, 32'h3, 32'h2, 32'h1}};

        #1 reset = 1'b1;
        #2;
        check("rst_ready", {31'd0, rdy_a}, 32'd0);
        check("rst_last", {31'd0, last_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_dout", dout_a, 32'd0);
        check("rst_busy_b", {31'd0, busy_b}, 32'd0);
        #9 reset = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++)
            burst(vecs[v].r, vecs[v].w, vecs[v].a, vecs[v].d, vecs[v].hold, vecs[v].drop_early);

        // Reset during beat 2 of a writeback: beats 0 and 1 must persist.
        burst(1'b0, 1'b1, 9'h1F8, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 0, 1'b0);
        wr = 1'b1; addr = 9'h1F8; din = 32'h11;
        edges = 0;
        do begin @(posedge clk); #1; edges++; end while (!rdy && edges < 20);
        check("rstw_latency", edges, 3);
        din = 32'h11; @(posedge clk); #1;
        din = 32'h22; @(posedge clk); #1;
        din = 32'h33;
        check("rstw_beat2_ready", {31'd0, rdy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rstw_ready", {31'd0, rdy}, 32'd0);
        check("rstw_last", {31'd0, last}, 32'd0);
        check("rstw_busy", {31'd0, busy}, 32'd0);
        check("rstw_dout", dout, 32'd0);
        #2 reset = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
        last_rd = '0;
        exp_q.delete();
        burst(1'b1, 1'b0, 9'h1F8, {32'hC3, 32'hC2, 32'h22, 32'h11}, 0, 1'b0);

        // LATENCY=1 instance: top line must not wrap into line 0.
        sel = 1'b1;
        last_rd = '0;
        burst(1'b0, 1'b1, 9'h000, {32'h7A, 32'h79, 32'h78, 32'h77}, 0, 1'b0);
        burst(1'b0, 1'b1, 9'h1FC, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 0, 1'b0);
        burst(1'b1, 1'b0, 9'h1FE, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 0, 1'b0);
        burst(1'b1, 1'b0, 9'h000, {32'h7A, 32'h79, 32'h78, 32'h77}, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
